// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic operand feed path.
// Buffer command codes, controller FSM states and default array size.
package systolic_pkg;

  localparam int ARR_SIZE_DEF = 4;

  localparam logic [1:0] BUF_CLEAR = 2'b00;
  localparam logic [1:0] BUF_PUSH  = 2'b01;
  localparam logic [1:0] BUF_POP   = 2'b10;
  localparam logic [1:0] BUF_HOLD  = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN,
    DONE
  } fsm_state_t;

endpackage

// File: rtl/skew_lane_decode.sv
// Per-lane buffer command decode from FSM state, drain time and length.
// Ports: state, t, len, in_valid in; cmd (2 bits per lane) out.
module skew_lane_decode
  import systolic_pkg::*;
#(
  parameter int ARR_SIZE = ARR_SIZE_DEF,
  parameter int LEN_W    = 4,
  parameter int T_W      = 4
) (
  input  fsm_state_t              state,
  input  logic [T_W-1:0]          t,
  input  logic [LEN_W-1:0]        len,
  input  logic                    in_valid,
  output logic [2*ARR_SIZE-1:0]   cmd
);

  localparam int CW = ((T_W > LEN_W) ? T_W : LEN_W) + 1;

  logic [CW-1:0] tx;
  logic [CW-1:0] lx;

  assign tx = CW'(t);
  assign lx = CW'(len);

  for (genvar i = 0; i < ARR_SIZE; i++) begin : g_lane
    localparam logic [CW-1:0] LANE = CW'(i);

    logic       pop;
    logic [1:0] cmd_l;

    // Lane i pops during the window [i, i+len); outside it the
    // buffer output is cleared so zeros fill the skew.
    assign pop = (tx >= LANE) && (tx < LANE + lx);

    always_comb begin
      cmd_l = BUF_CLEAR;
      unique case (1'b1)
        (state == LOAD):
          cmd_l = in_valid ? BUF_PUSH : BUF_HOLD;
        (state == DRAIN):
          cmd_l = pop ? BUF_POP : BUF_CLEAR;
        default:
          cmd_l = BUF_CLEAR;
      endcase
    end

    assign cmd[2*i+:2] = cmd_l;
  end

endmodule

// File: rtl/systolic_feed_controller.sv
// Load/skewed-drain sequencer for a bank of per-row operand buffers.
// Ports: clk, rst (async low), start, vec_len, in_valid in; in_ready,
// buf_state, out_valid, buf_clr, busy, done, err out.
module systolic_feed_controller
  import systolic_pkg::*;
#(
  parameter int ARR_SIZE    = ARR_SIZE_DEF,
  parameter int QUEUE_DEPTH = 2 * ARR_SIZE,
  parameter int LEN_W       = $clog2(QUEUE_DEPTH) + 1,
  parameter int T_W         = $clog2(QUEUE_DEPTH + ARR_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_W-1:0]      vec_len,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [2*ARR_SIZE-1:0] buf_state,
  output logic [ARR_SIZE-1:0]   out_valid,
  output logic                  buf_clr,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int CW = ((T_W > LEN_W) ? T_W : LEN_W) + 1;
  localparam logic [LEN_W-1:0] QD_L  = LEN_W'(QUEUE_DEPTH);
  localparam logic [CW-1:0]    TAIL  = CW'(ARR_SIZE - 2);

  fsm_state_t       state_q;
  fsm_state_t       state_d;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] len_d;
  logic [LEN_W-1:0] cnt_q;
  logic [LEN_W-1:0] cnt_d;
  logic [T_W-1:0]   t_q;
  logic [T_W-1:0]   t_d;
  logic             err_q;
  logic             err_d;
  logic [ARR_SIZE-1:0] ov_q;
  logic [ARR_SIZE-1:0] pop_now;
  logic [2*ARR_SIZE-1:0] cmd;

  logic len_ok;
  logic last_load;
  logic drain_end;

  assign len_ok    = (vec_len != '0) && (vec_len <= QD_L);
  assign last_load = (cnt_q == len_q - 1'b1);
  // Final drain cycle: the last lane's window closes at len+ARR_SIZE-2.
  assign drain_end = (CW'(t_q) == CW'(len_q) + TAIL);

  skew_lane_decode #(
    .ARR_SIZE (ARR_SIZE),
    .LEN_W    (LEN_W),
    .T_W      (T_W)
  ) u_decode (
    .state    (state_q),
    .t        (t_q),
    .len      (len_q),
    .in_valid (in_valid),
    .cmd      (cmd)
  );

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    t_d     = t_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (len_ok) begin
            len_d   = vec_len;
            cnt_d   = '0;
            state_d = LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (in_valid) begin
          cnt_d = cnt_q + 1'b1;
          if (last_load) begin
            t_d     = '0;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        t_d = t_q + 1'b1;
        if (drain_end) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    pop_now = '0;
    for (int i = 0; i < ARR_SIZE; i++) begin
      pop_now[i] = (cmd[2*i+:2] == BUF_POP);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      t_q     <= '0;
      err_q   <= 1'b0;
      ov_q    <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      t_q     <= t_d;
      err_q   <= err_d;
      ov_q    <= pop_now;
    end
  end

  assign buf_state = cmd;
  assign out_valid = ov_q;
  assign buf_clr   = ~rst;
  assign in_ready  = (state_q == LOAD);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign err       = err_q;

endmodule
